// File: rtl/fetch_control.sv
// Fetch-stage PC controller: boot vector, branch/stall handling, interrupt drain/vector and halt.
// Outputs are forced to the boot pattern while rst is low.
module fetch_control #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       branch_taken,
    input  logic       stall_req,
    input  logic       int_req,
    input  logic       halt_req,
    output logic       pc_enable,
    output logic [1:0] pc_selection,
    output logic       flush_if,
    output logic       int_ack,
    output logic       save_pc,
    output logic       halted
);

    typedef enum logic [2:0] {StBoot, StRun, StDrain, StVector, StHalted} state_e;

    localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

    state_e     r_state, w_state_next;
    logic       r_int_pending, w_int_pending_next;
    logic [3:0] r_drain_cnt, w_drain_cnt_next;

    logic       w_en, w_flush, w_ack, w_save, w_halted;
    logic [1:0] w_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StBoot;
            r_int_pending <= 1'b0;
            r_drain_cnt   <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_int_pending <= w_int_pending_next;
            r_drain_cnt   <= w_drain_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_int_pending_next = r_int_pending;
        w_drain_cnt_next   = 4'd0;
        w_en               = 1'b0;
        w_sel              = 2'b00;
        w_flush            = 1'b0;
        w_ack              = 1'b0;
        w_save             = 1'b0;
        w_halted           = 1'b0;

        unique case (r_state)
            StBoot: begin
                w_en         = 1'b1;
                w_sel        = 2'b11;
                w_flush      = 1'b1;
                w_state_next = StRun;
            end
            StRun: begin
                if (branch_taken) begin
                    w_en    = 1'b1;
                    w_sel   = 2'b01;
                    w_flush = 1'b1;
                end else if (stall_req) begin
                    w_en = 1'b0;
                end else if (r_int_pending) begin
                    w_flush          = 1'b1;
                    w_drain_cnt_next = DrainLoad;
                    w_state_next     = StDrain;
                end else if (halt_req) begin
                    w_state_next = StHalted;
                end else begin
                    w_en = 1'b1;
                end
            end
            StDrain: begin
                w_flush = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_state_next = StVector;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end
            end
            StVector: begin
                w_en               = 1'b1;
                w_sel              = 2'b10;
                w_flush            = 1'b1;
                w_ack              = 1'b1;
                w_save             = 1'b1;
                w_int_pending_next = 1'b0;
                w_state_next       = StRun;
            end
            StHalted: begin
                w_halted = 1'b1;
                if (r_int_pending) begin
                    w_drain_cnt_next = DrainLoad;
                    w_state_next     = StDrain;
                end
            end
            default: w_state_next = StBoot;
        endcase

        // A new request beats the VECTOR clear so back-to-back interrupts survive.
        if (int_req) begin
            w_int_pending_next = 1'b1;
        end
    end

    assign pc_enable    = rst & w_en;
    assign pc_selection = rst ? w_sel : 2'b11;
    assign flush_if     = ~rst | w_flush;
    assign int_ack      = rst & w_ack;
    assign save_pc      = rst & w_save;
    assign halted       = rst & w_halted;

endmodule

// File: tb/tb_fetch_control.sv
// Randomized and directed bench for fetch_control against a cycle-level behavioural model.
module tb_fetch_control;

    localparam int unsigned D = 3;

    logic       clk = 1'b0;
    logic       rst, branch_taken, stall_req, int_req, halt_req;
    logic       pc_enable, flush_if, int_ack, save_pc, halted;
    logic [1:0] pc_selection;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack = 0;
    logic prev_ack = 1'b0;

    // Model: booted flag, pending interrupt, cycles left in the drain+vector sequence, halt flag.
    bit m_booted  = 1'b0;
    bit m_pending = 1'b0;
    int m_seq     = 0;
    bit m_halted  = 1'b0;

    fetch_control #(.DRAIN_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_taken(branch_taken),
        .stall_req   (stall_req),
        .int_req     (int_req),
        .halt_req    (halt_req),
        .pc_enable   (pc_enable),
        .pc_selection(pc_selection),
        .flush_if    (flush_if),
        .int_ack     (int_ack),
        .save_pc     (save_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Packing: {0, halted, save_pc, int_ack, flush_if, sel[1:0], en}
    function automatic logic [7:0] pk(input bit en, input bit [1:0] sel, input bit fl,
                                      input bit ack, input bit hl);
        return {1'b0, hl, ack, ack, fl, sel, en};
    endfunction

    task automatic step(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        bit clr;
        #4;
        clr = 1'b0;
        if (!rst) begin
            e = pk(0, 2'b11, 1, 0, 0);
            m_booted = 0; m_pending = 0; m_seq = 0; m_halted = 0;
        end else begin
            if (!m_booted) begin
                e = pk(1, 2'b11, 1, 0, 0);
                m_booted = 1;
            end else if (m_seq > 0) begin
                if (m_seq == 1) begin
                    e = pk(1, 2'b10, 1, 1, 0);
                    clr = 1'b1;
                end else begin
                    e = pk(0, 2'b00, 1, 0, 0);
                end
                m_seq--;
            end else if (m_halted) begin
                e = pk(0, 2'b00, 0, 0, 1);
                if (m_pending) begin
                    m_halted = 0;
                    m_seq = D + 1;
                end
            end else if (branch_taken) begin
                e = pk(1, 2'b01, 1, 0, 0);
            end else if (stall_req) begin
                e = pk(0, 2'b00, 0, 0, 0);
            end else if (m_pending) begin
                e = pk(0, 2'b00, 1, 0, 0);
                m_seq = D + 1;
            end else if (halt_req) begin
                e = pk(0, 2'b00, 0, 0, 0);
                m_halted = 1;
            end else begin
                e = pk(1, 2'b00, 0, 0, 0);
            end
            if (clr) m_pending = 0;
            if (int_req) m_pending = 1;
        end
        o = {1'b0, halted, save_pc, int_ack, flush_if, pc_selection, pc_enable};
        check_eq(tag, o, e);
        check_eq({tag, "_ack_run"}, {7'd0, prev_ack & int_ack}, 8'd0);
        prev_ack = int_ack;
        if (int_ack) n_ack++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit b, input bit s, input bit i, input bit h,
                         input string tag);
        rst = r; branch_taken = b; stall_req = s; int_req = i; halt_req = h;
        step(tag);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, "reset");
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 0, "boot_run");

        drive(1, 1, 1, 0, 0, "branch_vs_stall");
        drive(1, 0, 0, 0, 0, "idle");

        n_ack = 0;
        drive(1, 0, 0, 1, 0, "int_pulse");
        for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 0, "int_seq");
        check_eq("int_ack_count", 8'(n_ack), 8'd1);

        drive(1, 0, 0, 0, 1, "halt_req");
        for (int k = 0; k < 20; k++) drive(1, 1, 1, 0, 1, "halted_hold");
        drive(1, 0, 0, 1, 0, "halt_int");
        for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 0, "halt_wake");

        n_ack = 0;
        drive(1, 0, 0, 1, 0, "b2b_first");
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 0, "b2b_drain");
        drive(1, 0, 0, 1, 0, "b2b_on_vector");
        for (int k = 0; k < 12; k++) drive(1, 0, 0, 0, 0, "b2b_tail");
        check_eq("b2b_ack_count", 8'(n_ack), 8'd2);

        n_ack = 0;
        drive(1, 0, 0, 1, 0, "rst_int");
        drive(1, 0, 0, 0, 0, "rst_run_pend");
        drive(1, 0, 0, 0, 0, "rst_drain1");
        drive(0, 0, 0, 0, 0, "rst_drain2");
        drive(0, 0, 0, 0, 0, "rst_hold");
        for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 0, "rst_after");
        check_eq("rst_abort_ack", 8'(n_ack), 8'd0);

        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 15) == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
